jk_excitation_driver: RTL

- Inverse of the JK flip-flop. The flip-flop maps (j,k) to the next q; this block maps a requested q sequence to the (j,k) excitation that produces it.
- Accepts target bits over a valid/ready handshake and buffers them in a small FIFO.
- Drives j/k into an external JK flip-flop, then checks the flip-flop's q feedback against each target.
- Serves as a stimulus/self-check engine around JK-style storage cells.

---
 rtl/jk_drv_pkg.sv | 33 +++
 rtl/jk_tgt_fifo.sv | 69 ++++++
 rtl/jk_excitation_driver.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/jk_drv_pkg.sv
// jk_drv_pkg
//   Shared types and helpers for the JK excitation driver:
//   - drv_state_e : sequencing FSM states (IDLE, APPLY, CHECK)
//   - TGT_DEPTH / TGT_PTR_W : default target FIFO depth and its pointer width
//   - excite()    : maps a (current q, requested q) pair onto the {j,k} that
//                   makes a JK flip-flop perform that transition
package jk_drv_pkg;

    localparam int unsigned TGT_DEPTH = 4;
    localparam int unsigned TGT_PTR_W = $clog2(TGT_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2
    } drv_state_e;

    // Hold transitions use j=k=0. For a real transition one input is forced
    // and the other is a don't-care; toggle_pref picks 0 (set/reset style)
    // or 1 (toggle style) for that don't-care.
    function automatic logic [1:0] excite(input logic q_exp,
                                          input logic tgt,
                                          input logic toggle_pref);
        logic [1:0] jk;
        unique case ({q_exp, tgt})
            2'b01:   jk = {1'b1, toggle_pref};
            2'b10:   jk = {toggle_pref, 1'b1};
            default: jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_tgt_fifo.sv
// jk_tgt_fifo
//   Synchronous single-bit FIFO holding requested q values.
//   Ports:
//     clk      in   rising-edge clock
//     rst      in   synchronous active-high flush
//     push_i   in   write data_i (ignored while full)
//     data_i   in   bit to enqueue
//     pop_i    in   drop the head entry (ignored while empty)
//     data_o   out  head entry (valid while !empty_o)
//     full_o   out  DEPTH entries stored
//     empty_o  out  no entries stored
//     count_o  out  number of stored entries
module jk_tgt_fifo
    import jk_drv_pkg::*;
#(
    parameter int unsigned DEPTH = TGT_DEPTH,
    parameter int unsigned PTR_W = TGT_PTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             data_i,
    input  logic             pop_i,
    output logic             data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W:0]   count_o
);

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; a flush only clears the
    // pointers and count, so stale entries are never observable.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver
//   Turns a stream of requested q values into J/K excitation for an external
//   JK flip-flop and checks the flip-flop's q feedback against each request.
//   Each target takes three cycles: IDLE (pop + register j/k), APPLY (the
//   flip-flop samples j/k), CHECK (compare q_fb, update counters).
//   Ports:
//     clk         in   rising-edge clock
//     rst         in   synchronous active-high reset (shared with the flop)
//     tgt_valid   in   target bit offered
//     tgt_bit     in   requested next q value
//     tgt_ready   out  FIFO not full
//     j, k        out  registered excitation
//     q_fb        in   q from the driven flip-flop
//     busy        out  work queued or in flight
//     mismatch    out  one-cycle pulse on a failed check
//     done_count  out  completed targets, wrapping
//     err_count   out  failed checks, saturating
module jk_excitation_driver
    import jk_drv_pkg::*;
#(
    parameter int unsigned DEPTH       = TGT_DEPTH,
    parameter int unsigned CNT_W       = 8,
    parameter bit          TOGGLE_PREF = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    output logic             j,
    output logic             k,
    input  logic             q_fb,
    output logic             busy,
    output logic             mismatch,
    output logic [CNT_W-1:0] done_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    drv_state_e       state_q, state_d;
    logic             cur_tgt_q, cur_tgt_d;
    logic             q_exp_q, q_exp_d;
    logic             j_q, j_d;
    logic             k_q, k_d;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] done_q, done_d;
    logic [CNT_W-1:0] err_q, err_d;

    logic             fifo_pop;
    logic             fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PTR_W:0]   fifo_count;

    jk_tgt_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tgt_valid),
        .data_i  (tgt_bit),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign tgt_ready  = !fifo_full;
    assign busy       = (fifo_count != '0) || (state_q != IDLE);
    assign j          = j_q;
    assign k          = k_q;
    assign mismatch   = mismatch_q;
    assign done_count = done_q;
    assign err_count  = err_q;

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cur_tgt_d  = cur_tgt_q;
        q_exp_d    = q_exp_q;
        j_d        = 1'b0;
        k_d        = 1'b0;
        mismatch_d = 1'b0;
        done_d     = done_q;
        err_d      = err_q;
        fifo_pop   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    cur_tgt_d  = fifo_head;
                    {j_d, k_d} = excite(q_exp_q, fifo_head, TOGGLE_PREF);
                    state_d    = APPLY;
                end
            end
            APPLY: begin
                state_d = CHECK;
            end
            CHECK: begin
                // Resync to what the flop really holds so one bad bit does
                // not corrupt the excitation of every following target.
                q_exp_d = q_fb;
                done_d  = done_q + CNT_W'(1);
                if (q_fb != cur_tgt_q) begin
                    mismatch_d = 1'b1;
                    if (err_q != '1) err_d = err_q + CNT_W'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_tgt_q  <= 1'b0;
            q_exp_q    <= 1'b0;
            j_q        <= 1'b0;
            k_q        <= 1'b0;
            mismatch_q <= 1'b0;
            done_q     <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            cur_tgt_q  <= cur_tgt_d;
            q_exp_q    <= q_exp_d;
            j_q        <= j_d;
            k_q        <= k_d;
            mismatch_q <= mismatch_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule
